// File: rtl/caesar_step_sequencer.sv
// Step sequencer for the Caesar display demo: paces the letter counter and runs one cipher req/ack per tick.
// Define CAESAR_SELFCHECK_EN to add an inverse round-trip transaction per step that flags mismatches on err_check.
module caesar_step_sequencer #(
  parameter int TICK_DIV    = 50000000,
  parameter int ACK_TIMEOUT = 15,
  parameter int ALPHA_LEN   = 26
) (
  input  logic       CLOCK_50,
  input  logic       rst,
  input  logic       run,
  input  logic       encrypt,
  input  logic [4:0] key,
  output logic       cph_req,
  input  logic       cph_ack,
  output logic       cph_mode,
  output logic [4:0] cph_key,
  output logic [5:0] cph_in,
  input  logic [5:0] cph_out,
  output logic [5:0] disp_key,
  output logic [5:0] disp_src,
  output logic [5:0] disp_dst,
  output logic       busy,
  output logic       err_key,
  output logic       err_timeout,
  output logic       overrun,
  output logic       err_check
);
  localparam int DIV_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam int TMO_W = $clog2(ACK_TIMEOUT + 1);
`ifdef CAESAR_SELFCHECK_EN
  localparam bit SELFCHECK = 1'b1;
`else
  localparam bit SELFCHECK = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, COMMIT} state_t;

  state_t           state_q, state_d;
  logic [DIV_W-1:0] div_q;
  logic [TMO_W-1:0] tmo_q;
  logic [5:0]       letter_q;
  logic [5:0]       res_q;
  logic             tick;
  logic             ack_hit, tmo_hit, do_issue, do_commit;
  logic             chk_phase;

  function automatic logic key_wraps(input logic [4:0] k);
    return {1'b0, k} >= 6'(ALPHA_LEN);
  endfunction

  function automatic logic [4:0] sanitise_key(input logic [4:0] k);
    return key_wraps(k) ? k - 5'(ALPHA_LEN) : k;
  endfunction

  function automatic logic [5:0] next_letter(input logic [5:0] l);
    return (l == 6'(ALPHA_LEN - 1)) ? 6'd0 : l + 6'd1;
  endfunction

  assign tick = (div_q == DIV_W'(TICK_DIV - 1));

  always_ff @(posedge CLOCK_50) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (tick && run) state_d = ISSUE;
      ISSUE:   state_d = WAIT;
      WAIT: begin
        if (ack_hit)      state_d = (SELFCHECK && !chk_phase) ? ISSUE : COMMIT;
        else if (tmo_hit) state_d = IDLE;
      end
      COMMIT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy      = (state_q != IDLE);
    do_issue  = (state_q == ISSUE);
    do_commit = (state_q == COMMIT);
    ack_hit   = (state_q == WAIT) && cph_ack;
    tmo_hit   = (state_q == WAIT) && !cph_ack && (tmo_q == TMO_W'(ACK_TIMEOUT - 1));
  end

  // Issue/wait/commit registers; the WAIT counter restarts on every ISSUE
  always_ff @(posedge CLOCK_50) begin
    if (rst) begin
      div_q       <= '0;
      tmo_q       <= '0;
      letter_q    <= '0;
      cph_req     <= 1'b0;
      cph_mode    <= 1'b0;
      cph_key     <= '0;
      cph_in      <= '0;
      disp_key    <= '0;
      disp_src    <= '0;
      disp_dst    <= '0;
      err_key     <= 1'b0;
      err_timeout <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      div_q <= tick ? '0 : div_q + DIV_W'(1);
      tmo_q <= (state_q == WAIT) ? tmo_q + TMO_W'(1) : '0;
      if (tick && busy) overrun <= 1'b1;
      if (do_issue) begin
        cph_req <= 1'b1;
        if (chk_phase) begin
          cph_mode <= ~cph_mode;
          cph_in   <= res_q;
        end else begin
          cph_mode <= encrypt;
          cph_key  <= sanitise_key(key);
          cph_in   <= letter_q;
          err_key  <= key_wraps(key);
        end
      end
      if (ack_hit || tmo_hit) cph_req <= 1'b0;
      if (tmo_hit) err_timeout <= 1'b1;
      if (do_commit) begin
        disp_src <= letter_q;
        disp_dst <= res_q;
        disp_key <= {1'b0, cph_key};
        letter_q <= next_letter(letter_q);
      end
    end
  end

  // The cipher result is plain data and needs no reset; it is only read after an ack
  always_ff @(posedge CLOCK_50) begin
    if (ack_hit && !chk_phase) res_q <= cph_out;
  end

`ifdef CAESAR_SELFCHECK_EN
  logic chk_q;

  always_ff @(posedge CLOCK_50) begin
    if (rst) begin
      chk_q     <= 1'b0;
      err_check <= 1'b0;
    end else begin
      if (ack_hit && !chk_q)          chk_q <= 1'b1;
      else if (do_commit || tmo_hit)  chk_q <= 1'b0;
      if (ack_hit && chk_q && (cph_out != letter_q)) err_check <= 1'b1;
    end
  end

  assign chk_phase = chk_q;
`else
  assign chk_phase = 1'b0;
  assign err_check = 1'b0;
`endif

endmodule

// File: tb/tb_caesar_step_sequencer.sv
// Directed bench for caesar_step_sequencer: an event/age-based reference model checked every cycle,
// plus literal expectations for each step.
module tb_caesar_step_sequencer;
  localparam int TD = 8;
  localparam int AT = 15;
  localparam int AL = 26;

  logic       clk = 1'b0;
  logic       rst, run, encrypt;
  logic [4:0] key;
  logic       cph_req, cph_ack, cph_mode;
  logic [4:0] cph_key;
  logic [5:0] cph_in;
  logic [5:0] cph_out = 6'd0;
  logic [5:0] disp_key, disp_src, disp_dst;
  logic       busy, err_key, err_timeout, overrun, err_check;
  logic       resp_ack = 1'b0;
  logic       late_ack = 1'b0;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int ack_delay = 1;
  bit never_ack = 1'b0;

  always #5 clk = ~clk;

  assign cph_ack = resp_ack | late_ack;

  caesar_step_sequencer #(.TICK_DIV(TD), .ACK_TIMEOUT(AT), .ALPHA_LEN(AL)) dut (
    .CLOCK_50(clk), .rst(rst), .run(run), .encrypt(encrypt), .key(key),
    .cph_req(cph_req), .cph_ack(cph_ack), .cph_mode(cph_mode), .cph_key(cph_key),
    .cph_in(cph_in), .cph_out(cph_out), .disp_key(disp_key), .disp_src(disp_src),
    .disp_dst(disp_dst), .busy(busy), .err_key(err_key), .err_timeout(err_timeout),
    .overrun(overrun), .err_check(err_check)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  function automatic logic [5:0] cipher(input logic m, input logic [5:0] v, input logic [4:0] k);
    int r;
    r = m ? (int'(v) + int'(k)) % AL : (int'(v) - int'(k) + AL) % AL;
    return 6'(r);
  endfunction

  // Cipher unit stand-in: acks ack_delay cycles into the request, or never
  int wait_n = 0;
  always @(posedge clk) begin
    #1;
    if (cph_req !== 1'b1) begin
      wait_n   = 0;
      resp_ack = 1'b0;
    end else begin
      resp_ack = !never_ack && (wait_n == ack_delay);
      if (resp_ack) cph_out = cipher(cph_mode, cph_in, cph_key);
      wait_n++;
    end
  end

  // Reference model: a transaction is tracked by its age in cycles since the accepted tick
  bit         mv = 1'b0;
  int         since, letter, t0;
  bit         txn, acked;
  logic       m_req, m_busy, m_mode, m_ekey, m_eto, m_ovr;
  logic [4:0] m_key;
  logic [5:0] m_in, m_dkey, m_dsrc, m_ddst, m_res;

  always @(negedge clk) begin
    int age;
    bit tk;
    if (mv) begin
      check("cph_req", cph_req, m_req);
      check("busy", busy, m_busy);
      check("cph_mode", cph_mode, m_mode);
      check("cph_key", cph_key, m_key);
      check("cph_in", cph_in, m_in);
      check("disp_key", disp_key, m_dkey);
      check("disp_src", disp_src, m_dsrc);
      check("disp_dst", disp_dst, m_ddst);
      check("err_key", err_key, m_ekey);
      check("err_timeout", err_timeout, m_eto);
      check("overrun", overrun, m_ovr);
      check("err_check", err_check, 1'b0);
    end
    if (rst === 1'b1) begin
      mv = 1'b1; since = 0; letter = 0; txn = 1'b0; acked = 1'b0;
      m_req = 0; m_busy = 0; m_mode = 0; m_ekey = 0; m_eto = 0; m_ovr = 0;
      m_key = '0; m_in = '0; m_dkey = '0; m_dsrc = '0; m_ddst = '0; m_res = '0;
    end else if (mv) begin
      tk = (since % TD) == TD - 1;
      since++;
      if (txn) begin
        age = cyc - t0;
        if (tk) m_ovr = 1'b1;
        if (age == 1) begin
          m_mode = encrypt;
          m_key  = (key >= AL) ? key - 5'(AL) : key;
          m_ekey = (key >= AL);
          m_in   = 6'(letter);
          m_req  = 1'b1;
        end else if (!acked) begin
          if (cph_ack === 1'b1) begin
            acked = 1'b1; m_res = cph_out; m_req = 1'b0;
          end else if (age - 1 == AT) begin
            m_req = 1'b0; m_eto = 1'b1; txn = 1'b0;
          end
        end else begin
          m_dsrc = m_in; m_ddst = m_res; m_dkey = {1'b0, m_key};
          letter = (letter + 1) % AL;
          txn = 1'b0;
        end
      end else if (tk && run) begin
        txn = 1'b1; t0 = cyc; acked = 1'b0;
      end
      m_busy = txn;
    end
    cyc++;
  end

  task automatic wait_step(output int reqs);
    int n;
    bit started;
    reqs = 0;
    n = 0;
    while (busy !== 1'b1 && n < 64) begin @(negedge clk); n++; end
    started = (busy === 1'b1);
    while (busy === 1'b1 && n < 128) begin
      @(negedge clk); n++;
      if (cph_req === 1'b1) reqs++;
    end
    check("step_completed", (started && busy === 1'b0) ? 1 : 0, 1);
  endtask

  task automatic do_step(input string tag, input int src, input int dst);
    int r;
    wait_step(r);
    check({tag, "_src"}, disp_src, src);
    check({tag, "_dst"}, disp_dst, dst);
  endtask

  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  initial begin
    int r;
    int frz;
    rst = 1'b1; run = 1'b0; encrypt = 1'b1; key = 5'd3;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_req", cph_req, 0);
    check("rst_busy", busy, 0);
    check("rst_disp_src", disp_src, 0);
    check("rst_overrun", overrun, 0);
    next_cycle(); rst = 1'b0; run = 1'b1;

    do_step("basic0", 0, 3);
    check("basic0_key", disp_key, 3);
    check("basic0_err_key", err_key, 0);
    do_step("basic1", 1, 4);
    do_step("basic2", 2, 5);

    next_cycle(); key = 5'd29;
    do_step("key29", 3, 6);
    check("key29_cph_key", cph_key, 3);
    check("key29_disp_key", disp_key, 3);
    check("key29_err_key", err_key, 1);
    next_cycle(); key = 5'd25;
    do_step("key25", 4, 3);
    check("key25_disp_key", disp_key, 25);
    check("key25_err_key", err_key, 0);

    next_cycle(); encrypt = 1'b0; key = 5'd5;
    do_step("decrypt", 5, 0);
    check("decrypt_mode", cph_mode, 0);
    next_cycle(); encrypt = 1'b1; key = 5'd3;

    for (int i = 6; i < 25; i++) wait_step(r);
    do_step("wrap25", 25, 2);
    do_step("wrap0", 0, 3);

    check("no_overrun_yet", overrun, 0);
    next_cycle(); ack_delay = 9;
    do_step("slow_ack", 1, 4);
    check("slow_ack_overrun", overrun, 1);
    next_cycle(); ack_delay = 1; never_ack = 1'b1;
    wait_step(r);
    check("timeout_req_cycles", r, AT);
    check("timeout_flag", err_timeout, 1);
    check("timeout_disp_src", disp_src, 1);
    next_cycle(); never_ack = 1'b0;
    do_step("after_timeout", 2, 5);

    next_cycle(); run = 1'b0;
    frz = 0;
    for (int i = 0; i < 5 * TD; i++) begin
      @(negedge clk);
      if (cph_req === 1'b1 || busy === 1'b1) frz++;
    end
    check("freeze_activity", frz, 0);
    check("freeze_disp_src", disp_src, 2);
    next_cycle(); run = 1'b1;
    do_step("unfreeze", 3, 6);

    next_cycle(); never_ack = 1'b1;
    frz = 0;
    while (cph_req !== 1'b1 && frz < 64) begin @(negedge clk); frz++; end
    check("reset_saw_req", cph_req, 1);
    next_cycle(); rst = 1'b1;
    next_cycle(); rst = 1'b0; late_ack = 1'b1;
    @(negedge clk);
    check("midrst_req", cph_req, 0);
    check("midrst_busy", busy, 0);
    check("midrst_disp_src", disp_src, 0);
    check("midrst_disp_dst", disp_dst, 0);
    check("midrst_overrun", overrun, 0);
    next_cycle(); late_ack = 1'b0; never_ack = 1'b0;
    do_step("resume", 0, 3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog at cycle %0d: got no finish, expected finish", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
